// File: rtl/uart_pkg.sv
// Shared constants, banner ROM and generator state encoding for the UART echo endpoint.
package uart_pkg;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LVL   = 1'b1;

    localparam int unsigned BANNER_LEN = 19;
    localparam logic [7:0] BANNER [0:BANNER_LEN-1] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h50, 8'h61, 8'h6E, 8'h67,
        8'h6F, 8'h20, 8'h46, 8'h50, 8'h47, 8'h41, 8'h21, 8'h0D, 8'h0A
    };

    typedef enum logic [2:0] {
        IDLE,
        MSG_LOAD,
        MSG_WAIT,
        ECHO_LOAD,
        ECHO_WAIT
    } gen_state_t;

    // Indices past the ROM read as zero so a longer MSG_LEN stays well defined.
    function automatic logic [7:0] banner_byte(input logic [7:0] i);
        return (32'(i) < BANNER_LEN) ? BANNER[5'(i)] : 8'h00;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: free-runs while enabled, strobing at mid-bit and on the last cycle of each bit.
module uart_baud_cnt #(
    parameter logic [15:0] BPS_NUM = 16'd434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mid_c,
    output logic end_c
);

    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || end_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign mid_c = en && (cnt == (BPS_NUM >> 1));
    assign end_c = en && (cnt == (BPS_NUM - CNT_W'(1)));

endmodule

// File: rtl/uart_msg_echo.sv
// 8N1 UART bring-up endpoint: sends a banner on a debounced key press and echoes every good received byte.
module uart_msg_echo
    import uart_pkg::*;
#(
    parameter logic [15:0] BPS_NUM    = 16'd434,
    parameter logic [7:0]  MSG_LEN    = 8'd19,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    input  logic       key,
    output logic       uart_tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_busy
);

    localparam int unsigned BIT_W = $clog2(FRAME_BITS);
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    // Key synchronizer and stable-level debounce; press fires on the debounced falling edge.
    logic             key_s1, key_s2, key_deb, press;
    logic [DEB_W-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1  <= 1'b1;
            key_s2  <= 1'b1;
            key_deb <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            press  <= 1'b0;
            if (key_s2 == key_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                deb_cnt <= '0;
                key_deb <= key_s2;
                press   <= ~key_s2;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Receiver: start edge arms the bit timer, samples land on the mid-bit strobe.
    logic                 rx_s1, rx_s2, rx_prev, rx_busy;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_mid_c, rx_end_c;

    uart_baud_cnt #(.BPS_NUM(BPS_NUM)) u_rx_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rx_busy),
        .mid_c (rx_mid_c),
        .end_c (rx_end_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= IDLE_LVL;
            rx_s2    <= IDLE_LVL;
            rx_prev  <= IDLE_LVL;
            rx_busy  <= 1'b0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_bit  <= '0;
                end
            end else if (rx_mid_c) begin
                if (rx_bit == '0) begin
                    if (rx_s2) rx_busy <= 1'b0;
                end else if (rx_bit == BIT_W'(FRAME_BITS - 1)) begin
                    // Freed at mid-stop so a back-to-back start edge is not missed.
                    rx_busy <= 1'b0;
                    if (rx_s2) begin
                        rx_data  <= rx_shreg;
                        rx_valid <= 1'b1;
                    end
                end else begin
                    rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
                end
            end else if (rx_end_c) begin
                rx_bit <= rx_bit + BIT_W'(1);
            end
        end
    end

    // Transmitter: uart_tx always holds the bit currently on the line.
    logic                 tx_pulse_c;
    logic [7:0]           tx_data_c;
    logic [DATA_BITS:0]   tx_shreg;
    logic [BIT_W-1:0]     tx_bit;
    logic                 tx_end_c, tx_mid_unused;

    uart_baud_cnt #(.BPS_NUM(BPS_NUM)) u_tx_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tx_busy),
        .mid_c (tx_mid_unused),
        .end_c (tx_end_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx  <= IDLE_LVL;
            tx_busy  <= 1'b0;
            tx_shreg <= '1;
            tx_bit   <= '0;
        end else if (!tx_busy) begin
            if (tx_pulse_c) begin
                tx_busy  <= 1'b1;
                uart_tx  <= ~IDLE_LVL;
                tx_shreg <= {IDLE_LVL, tx_data_c};
                tx_bit   <= '0;
            end
        end else if (tx_end_c) begin
            if (tx_bit == BIT_W'(FRAME_BITS - 1)) begin
                tx_busy <= 1'b0;
                uart_tx <= IDLE_LVL;
            end else begin
                uart_tx  <= tx_shreg[0];
                tx_shreg <= {IDLE_LVL, tx_shreg[DATA_BITS:1]};
                tx_bit   <= tx_bit + BIT_W'(1);
            end
        end
    end

    // Generator FSM plus single-entry echo buffer (newest byte wins).
    gen_state_t state, state_nxt;
    logic [7:0] idx, idx_nxt;
    logic       echo_full, echo_clr_c;
    logic [7:0] echo_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            echo_full <= 1'b0;
            echo_data <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (rx_valid) begin
                echo_full <= 1'b1;
                echo_data <= rx_data;
            end else if (echo_clr_c) begin
                echo_full <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        tx_pulse_c = 1'b0;
        tx_data_c  = banner_byte(idx);
        echo_clr_c = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    state_nxt = MSG_LOAD;
                    idx_nxt   = '0;
                end else if (echo_full) begin
                    state_nxt = ECHO_LOAD;
                end
            end
            MSG_LOAD: begin
                if (!tx_busy) begin
                    tx_pulse_c = 1'b1;
                    state_nxt  = MSG_WAIT;
                end
            end
            // tx_busy is already high on entry, so its fall marks the end of the frame.
            MSG_WAIT: begin
                if (!tx_busy) begin
                    if (idx == MSG_LEN - 8'd1) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx + 8'd1;
                        state_nxt = MSG_LOAD;
                    end
                end
            end
            ECHO_LOAD: begin
                tx_data_c = echo_data;
                if (!tx_busy) begin
                    tx_pulse_c = 1'b1;
                    state_nxt  = ECHO_WAIT;
                end
            end
            ECHO_WAIT: begin
                if (!tx_busy) begin
                    echo_clr_c = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_msg_echo.sv
// Bench for uart_msg_echo: drives serial frames and key presses, decodes uart_tx independently.
module tb_uart_msg_echo;

    localparam int BPS = 16;
    localparam logic [7:0] BANNER_EXP [0:18] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h50, 8'h61, 8'h6E, 8'h67,
        8'h6F, 8'h20, 8'h46, 8'h50, 8'h47, 8'h41, 8'h21, 8'h0D, 8'h0A
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic       key;
    logic       uart_tx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;

    uart_msg_echo #(
        .BPS_NUM    (16'd16),
        .MSG_LEN    (8'd19),
        .DEB_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .key      (key),
        .uart_tx  (uart_tx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pulse and busy-length monitor
    int   rx_cnt = 0;
    int   wide_cnt = 0;
    int   busy_run = 0;
    int   last_busy = 0;
    logic rx_v_d = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (rx_valid && rx_v_d) wide_cnt <= wide_cnt + 1;
        rx_v_d <= rx_valid;
        if (tx_busy) begin
            busy_run <= busy_run + 1;
        end else begin
            if (busy_run != 0) last_busy <= busy_run;
            busy_run <= 0;
        end
    end

    // Independent uart_tx decoder
    typedef struct {
        logic [7:0] d;
        logic       stop_ok;
        int         start_cyc;
    } frm_t;

    frm_t       tx_q[$];
    frm_t       dec_frm;
    int         dec_start;
    logic [7:0] dec_byte;

    initial begin : decoder
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0 && rst_n === 1'b1) begin
                dec_start = cyc;
                repeat (BPS / 2 - 1) @(negedge clk);
                if (uart_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BPS) @(negedge clk);
                        dec_byte[i] = uart_tx;
                    end
                    repeat (BPS) @(negedge clk);
                    dec_frm.d         = dec_byte;
                    dec_frm.stop_ok   = uart_tx;
                    dec_frm.start_cyc = dec_start;
                    tx_q.push_back(dec_frm);
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (BPS) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_glitch(input int len);
        uart_rx = 1'b0;
        repeat (len) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic press_key(input int len);
        key = 1'b0;
        repeat (len) @(negedge clk);
        key = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (tx_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    // Pops up to n frames and counts departures from the banner text.
    task automatic pop_banner(input int n, output int bad, output int max_gap);
        frm_t f;
        int   prev;
        bad     = 0;
        max_gap = 0;
        prev    = 0;
        for (int i = 0; i < n && tx_q.size() > 0; i++) begin
            f = tx_q.pop_front();
            if (f.d !== BANNER_EXP[i] || f.stop_ok !== 1'b1) bad++;
            if (i > 0 && (f.start_cyc - prev - 10 * BPS) > max_gap)
                max_gap = f.start_cyc - prev - 10 * BPS;
            prev = f.start_cyc;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         glitch;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    task automatic apply_vec(input vec_t v);
        int   c0;
        frm_t f;
        c0 = rx_cnt;
        if (v.glitch != 0) send_glitch(v.glitch);
        else send_frame(v.data, v.stop);
        repeat (400) @(negedge clk);
        check("vec_rx_valid_count", rx_cnt - c0, 32'(v.exp_valid));
        check("vec_rx_data", 32'(rx_data), 32'(v.exp_data));
        check("vec_echo_count", tx_q.size(), 32'(v.exp_valid));
        if (tx_q.size() > 0) begin
            f = tx_q.pop_front();
            check("vec_echo_byte", 32'(f.d), 32'(v.data));
            check("vec_echo_stop", 32'(f.stop_ok), 32'(1));
        end
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    vec_t       tbl[8];
    vec_t       rv;
    logic [7:0] model_last;
    logic [9:0] exp_bits;
    int         lows, busys, bad, gap, t, c0, kind;
    frm_t       fr;

    initial begin : main
        rst_n   = 1'b0;
        key     = 1'b1;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_uart_tx", 32'(uart_tx), 32'(1));
        check("reset_tx_busy", 32'(tx_busy), 32'(0));
        check("reset_rx_data", 32'(rx_data), 32'(0));
        check("reset_rx_valid", 32'(rx_valid), 32'(0));
        rst_n = 1'b1;

        // Quiet idle after reset
        lows  = 0;
        busys = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
            if (tx_busy !== 1'b0) busys++;
        end
        check("idle_tx_not_high_cycles", lows, 0);
        check("idle_busy_cycles", busys, 0);
        check("idle_rx_valid_count", rx_cnt, 0);
        check("idle_frames", tx_q.size(), 0);

        // A5 received, echoed bit by bit
        exp_bits = 10'b11_0100_1010;
        c0 = rx_cnt;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                t = 0;
                while (uart_tx !== 1'b0 && t < 600) begin
                    @(negedge clk);
                    t++;
                end
                for (int k = 0; k < 10; k++) begin
                    bad = 0;
                    for (int j = 0; j < BPS; j++) begin
                        if (uart_tx !== exp_bits[k]) bad++;
                        @(negedge clk);
                    end
                    check($sformatf("a5_echo_bit%0d_wrong_cycles", k), bad, 0);
                end
            end
        join
        repeat (50) @(negedge clk);
        check("a5_rx_valid_count", rx_cnt - c0, 1);
        check("a5_rx_data", 32'(rx_data), 32'hA5);
        check("a5_rx_valid_width", wide_cnt, 0);
        check("a5_tx_busy_cycles", last_busy, 10 * BPS);
        check("a5_echo_frames", tx_q.size(), 1);
        if (tx_q.size() > 0) begin
            fr = tx_q.pop_front();
            check("a5_echo_byte", 32'(fr.d), 32'hA5);
        end

        // Directed receive vectors: good frames, framing errors, start glitches
        tbl[0] = '{8'h00, 1'b1, 0, 1'b1, 8'h00};
        tbl[1] = '{8'hFF, 1'b1, 0, 1'b1, 8'hFF};
        tbl[2] = '{8'h3C, 1'b0, 0, 1'b0, 8'hFF};
        tbl[3] = '{8'h00, 1'b1, 4, 1'b0, 8'hFF};
        tbl[4] = '{8'h81, 1'b1, 0, 1'b1, 8'h81};
        tbl[5] = '{8'h7E, 1'b0, 0, 1'b0, 8'h81};
        tbl[6] = '{8'h00, 1'b1, 1, 1'b0, 8'h81};
        tbl[7] = '{8'h5A, 1'b1, 0, 1'b1, 8'h5A};
        for (int i = 0; i < 8; i++) apply_vec(tbl[i]);

        // Random receive traffic against the frame-rule model
        model_last = 8'h5A;
        for (int i = 0; i < 12; i++) begin
            kind       = int'($urandom_range(0, 3));
            rv.data    = 8'($urandom);
            rv.stop    = (kind != 1);
            rv.glitch  = (kind == 0) ? int'($urandom_range(1, 6)) : 0;
            rv.exp_valid = (kind >= 2);
            if (rv.exp_valid) model_last = rv.data;
            rv.exp_data = model_last;
            apply_vec(rv);
        end
        check("rx_valid_width_total", wide_cnt, 0);

        // Short key bounce is filtered
        press_key(5);
        repeat (400) @(negedge clk);
        check("bounce_no_frames", tx_q.size(), 0);

        // Key press sends the banner once
        press_key(20);
        wait_frames(19, 19 * 170 + 300);
        repeat (500) @(negedge clk);
        check("banner_frame_count", tx_q.size(), 19);
        pop_banner(19, bad, gap);
        check("banner_bad_bytes", bad, 0);
        check("banner_gap_within_3", 32'(gap <= 3), 32'(1));

        // Bytes arriving during the banner: only the last one is echoed afterwards
        press_key(20);
        repeat (400) @(negedge clk);
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        press_key(20);
        wait_frames(20, 22 * 170 + 500);
        repeat (600) @(negedge clk);
        check("banner_echo_frame_count", tx_q.size(), 20);
        pop_banner(19, bad, gap);
        check("banner_echo_bad_bytes", bad, 0);
        if (tx_q.size() > 0) begin
            fr = tx_q.pop_front();
            check("banner_echo_byte", 32'(fr.d), 32'h32);
        end
        check("banner_echo_rx_data", 32'(rx_data), 32'h32);

        // Reset mid-banner drops the frame and the pending echo
        press_key(20);
        repeat (300) @(negedge clk);
        send_frame(8'h55, 1'b1);
        wait_frames(5, 2000);
        repeat (40) @(negedge clk);
        check("rst_pre_busy", 32'(tx_busy), 32'(1));
        check("rst_pre_rx_data", 32'(rx_data), 32'h55);
        #2 rst_n = 1'b0;
        #1;
        check("rst_uart_tx_immediate", 32'(uart_tx), 32'(1));
        check("rst_tx_busy_immediate", 32'(tx_busy), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_rx_data_cleared", 32'(rx_data), 32'(0));
        repeat (300) @(negedge clk);
        tx_q.delete();
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("post_rst_idle_low_cycles", lows, 0);
        check("post_rst_frames", tx_q.size(), 0);
        press_key(20);
        wait_frames(19, 19 * 170 + 300);
        repeat (500) @(negedge clk);
        check("post_rst_banner_count", tx_q.size(), 19);
        pop_banner(19, bad, gap);
        check("post_rst_banner_bad_bytes", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
